// File: rtl/axi_bridge_pkg.sv
// Shared types and helpers for the multi-port CPU-to-AXI bridge.
//  - port_state_t : per-port request lifecycle
//  - AXI_BURST_INCR / AXI_RESP_OKAY : AXI encodings used by the bridge
//  - make_strobe  : byte-lane strobe for a naturally aligned single beat
package axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HAZARD,
        ST_ISSUE,
        ST_WAIT_RESP,
        ST_RESPOND
    } port_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Returns up to 8 lanes; callers narrower than 64 bits cast the result down.
    // A run of (1 << size) ones is built by right-shifting a full byte mask,
    // then moved up to the lane the address points at.
    function automatic logic [7:0] make_strobe(input logic [1:0] size, input logic [2:0] addr_lo);
        logic [3:0] bytes;
        logic [7:0] mask;
        bytes = 4'd1 << size;
        mask  = 8'hFF >> (4'd8 - bytes);
        return mask << addr_lo;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant locking.
//  clock, reset : rising-edge clock, synchronous active-high reset
//  req[N]       : requesters
//  lock         : keep the current grant in the next cycle (transfer stalled)
//  advance      : current grant completed; pointer moves one past the grantee
//  grant[N]     : one-hot grant (all zero when nothing requests)
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         lock,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] adv_ptr;
    logic [N-1:0]  grant_q;
    logic [N-1:0]  pick;
    logic          lock_q;
    logic          found;

    // Search from the pointer upward first, then wrap to the low indices.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr_q))) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    // A stalled transfer must keep the same grantee so payload and ID stay put.
    assign grant = lock_q ? grant_q : pick;

    always_comb begin
        adv_ptr = ptr_q;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                adv_ptr = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q   <= '0;
            grant_q <= '0;
            lock_q  <= 1'b0;
        end else begin
            grant_q <= grant;
            lock_q  <= lock;
            if (advance) begin
                ptr_q <= adv_ptr;
            end
        end
    end

endmodule

// File: rtl/cpu_axi_multiport_bridge.sv
// Bridges NUM_PORTS SRAM-like CPU request ports onto one single-beat AXI master.
// Port i uses AXI ID i; AR and AW are arbitrated round-robin independently.
// Reads stall while another port has a same-word write in flight.
//  clock, reset           : rising-edge clock, synchronous active-high reset
//  port_request/write/size/address/write_data : per-port request inputs
//  port_address_ready     : port can accept a request (idle)
//  port_data_ready        : one-cycle completion pulse
//  port_read_data/error   : response data and error, held until next completion
//  ar*/r*/aw*/w*/b*       : AXI master interface
module cpu_axi_multiport_bridge
    import axi_bridge_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_PORTS-1:0]                 port_request,
    input  logic [NUM_PORTS-1:0]                 port_write,
    input  logic [NUM_PORTS-1:0][1:0]            port_size,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] port_address,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_write_data,
    output logic [NUM_PORTS-1:0]                 port_address_ready,
    output logic [NUM_PORTS-1:0]                 port_data_ready,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_read_data,
    output logic [NUM_PORTS-1:0]                 port_error,
    output logic [ID_WIDTH-1:0]                  arid,
    output logic [ADDR_WIDTH-1:0]                araddr,
    output logic [7:0]                           arlen,
    output logic [2:0]                           arsize,
    output logic [1:0]                           arburst,
    output logic                                 arlock,
    output logic [3:0]                           arcache,
    output logic [2:0]                           arprot,
    output logic                                 arvalid,
    input  logic                                 arready,
    input  logic [ID_WIDTH-1:0]                  rid,
    input  logic [DATA_WIDTH-1:0]                rdata,
    input  logic [1:0]                           rresp,
    input  logic                                 rvalid,
    output logic                                 rready,
    output logic [ID_WIDTH-1:0]                  awid,
    output logic [ADDR_WIDTH-1:0]                awaddr,
    output logic [7:0]                           awlen,
    output logic [2:0]                           awsize,
    output logic [1:0]                           awburst,
    output logic                                 awlock,
    output logic [3:0]                           awcache,
    output logic [2:0]                           awprot,
    output logic                                 awvalid,
    input  logic                                 awready,
    output logic [ID_WIDTH-1:0]                  wid,
    output logic [DATA_WIDTH-1:0]                wdata,
    output logic [DATA_WIDTH/8-1:0]              wstrb,
    output logic                                 wlast,
    output logic                                 wvalid,
    input  logic                                 wready,
    input  logic [ID_WIDTH-1:0]                  bid,
    input  logic [1:0]                           bresp,
    input  logic                                 bvalid,
    output logic                                 bready
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);

    logic [NUM_PORTS-1:0]  ar_req, aw_req, ar_grant, aw_grant;
    logic [NUM_PORTS-1:0]  busy_write, aw_done, w_done, aw_fin;
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
    logic [1:0]            size_arr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];
    logic [STRB_W-1:0]     strb_arr  [NUM_PORTS];

    rr_arbiter #(.N(NUM_PORTS)) u_ar_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (ar_req),
        .lock    (arvalid && !arready),
        .advance (arvalid && arready),
        .grant   (ar_grant)
    );

    // The AW grantee owns both channels until AW and W have each handshaked.
    rr_arbiter #(.N(NUM_PORTS)) u_aw_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (aw_req),
        .lock    ((|aw_grant) && !(|aw_fin)),
        .advance (|aw_fin),
        .grant   (aw_grant)
    );

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        port_state_t           state_q, state_d;
        logic [ADDR_WIDTH-1:0] addr_q;
        logic [1:0]            size_q;
        logic                  write_q;
        logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
        logic [STRB_W-1:0]     strb_q;
        logic                  aw_done_q, w_done_q, err_q;
        logic                  hazard_in, hazard_q, resp_hit;

        // Word-granular compare against every other port's in-flight write;
        // hazard_in screens a request being accepted, hazard_q a parked one.
        always_comb begin
            hazard_in = 1'b0;
            hazard_q  = 1'b0;
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (j != g && busy_write[j]) begin
                    if (port_address[g][ADDR_WIDTH-1:LSB] == addr_arr[j][ADDR_WIDTH-1:LSB]) begin
                        hazard_in = 1'b1;
                    end
                    if (addr_q[ADDR_WIDTH-1:LSB] == addr_arr[j][ADDR_WIDTH-1:LSB]) begin
                        hazard_q = 1'b1;
                    end
                end
            end
        end

        assign resp_hit = write_q ? (bvalid && bid == ID_WIDTH'(g))
                                  : (rvalid && rid == ID_WIDTH'(g));
        assign aw_fin[g] = aw_grant[g] && (aw_done_q || awready) && (w_done_q || wready);

        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_IDLE:      if (port_request[g]) state_d = (!port_write[g] && hazard_in) ? ST_HAZARD : ST_ISSUE;
                ST_HAZARD:    if (!hazard_q) state_d = ST_ISSUE;
                ST_ISSUE:     if (write_q ? aw_fin[g] : (ar_grant[g] && arready)) state_d = ST_WAIT_RESP;
                ST_WAIT_RESP: if (resp_hit) state_d = ST_RESPOND;
                ST_RESPOND:   state_d = ST_IDLE;
                default:      state_d = ST_IDLE;
            endcase
        end

        // Response data and error are captured on the response handshake so
        // they become visible together with the completion pulse.
        always_ff @(posedge clock) begin
            if (reset) begin
                state_q   <= ST_IDLE;
                addr_q    <= '0;
                size_q    <= '0;
                write_q   <= 1'b0;
                wdata_q   <= '0;
                strb_q    <= '0;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                rdata_q   <= '0;
                err_q     <= 1'b0;
            end else begin
                state_q <= state_d;
                if (state_q == ST_IDLE && port_request[g]) begin
                    addr_q  <= port_address[g];
                    size_q  <= port_size[g];
                    write_q <= port_write[g];
                    wdata_q <= port_write_data[g];
                    strb_q  <= STRB_W'(make_strobe(port_size[g], 3'(port_address[g][LSB-1:0])));
                end
                if (state_q == ST_ISSUE && write_q) begin
                    if (aw_fin[g]) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end else begin
                        if (aw_grant[g] && awready) aw_done_q <= 1'b1;
                        if (aw_grant[g] && wready)  w_done_q  <= 1'b1;
                    end
                end
                if (state_q == ST_WAIT_RESP && resp_hit) begin
                    if (!write_q) rdata_q <= rdata;
                    err_q <= write_q ? (bresp != AXI_RESP_OKAY) : (rresp != AXI_RESP_OKAY);
                end
            end
        end

        assign ar_req[g]     = (state_q == ST_ISSUE) && !write_q;
        assign aw_req[g]     = (state_q == ST_ISSUE) && write_q;
        assign busy_write[g] = write_q && (state_q == ST_ISSUE || state_q == ST_WAIT_RESP);
        assign aw_done[g]    = aw_done_q;
        assign w_done[g]     = w_done_q;
        assign addr_arr[g]   = addr_q;
        assign size_arr[g]   = size_q;
        assign wdata_arr[g]  = wdata_q;
        assign strb_arr[g]   = strb_q;

        assign port_address_ready[g] = (state_q == ST_IDLE);
        assign port_data_ready[g]    = (state_q == ST_RESPOND);
        assign port_read_data[g]     = rdata_q;
        assign port_error[g]         = err_q;
    end

    // Channel payload follows the one-hot grants.
    always_comb begin
        arid   = '0;
        araddr = '0;
        arsize = '0;
        awid   = '0;
        awaddr = '0;
        awsize = '0;
        wdata  = '0;
        wstrb  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (ar_grant[i]) begin
                arid   = ID_WIDTH'(i);
                araddr = addr_arr[i];
                arsize = {1'b0, size_arr[i]};
            end
            if (aw_grant[i]) begin
                awid   = ID_WIDTH'(i);
                awaddr = addr_arr[i];
                awsize = {1'b0, size_arr[i]};
                wdata  = wdata_arr[i];
                wstrb  = strb_arr[i];
            end
        end
    end

    assign arvalid = |ar_grant;
    assign awvalid = |(aw_grant & ~aw_done);
    assign wvalid  = |(aw_grant & ~w_done);
    assign wid     = awid;

    assign arlen   = 8'd0;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 1'b0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awlen   = 8'd0;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 1'b0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wlast   = 1'b1;
    assign rready  = 1'b1;
    assign bready  = 1'b1;

endmodule

// File: tb/tb_cpu_axi_multiport_bridge.sv
// Self-checking bench for cpu_axi_multiport_bridge (2 ports, 32-bit data).
// A scoreboard holds the expected completion per port; the AXI slave side is
// driven directly by each scenario.
module tb_cpu_axi_multiport_bridge;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        port_request, port_write;
    logic [1:0][1:0]   port_size;
    logic [1:0][31:0]  port_address, port_write_data;
    logic [1:0]        port_address_ready, port_data_ready, port_error;
    logic [1:0][31:0]  port_read_data;
    logic [3:0]        arid, rid, awid, wid, bid;
    logic [31:0]       araddr, rdata, awaddr, wdata;
    logic [7:0]        arlen, awlen;
    logic [2:0]        arsize, arprot, awsize, awprot;
    logic [1:0]        arburst, rresp, awburst, bresp;
    logic [3:0]        arcache, awcache, wstrb;
    logic              arlock, arvalid, arready, rvalid, rready;
    logic              awlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        chk_data;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    cpu_axi_multiport_bridge dut (
        .clock(clock), .reset(reset),
        .port_request(port_request), .port_write(port_write), .port_size(port_size),
        .port_address(port_address), .port_write_data(port_write_data),
        .port_address_ready(port_address_ready), .port_data_ready(port_data_ready),
        .port_read_data(port_read_data), .port_error(port_error),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic applyStimulus(input int p, input logic wr, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] exp_data, input logic exp_err, input logic push);
        exp_t e;
        port_request[p]    = 1'b1;
        port_write[p]      = wr;
        port_size[p]       = size;
        port_address[p]    = addr;
        port_write_data[p] = wd;
        e.data     = exp_data;
        e.err      = exp_err;
        e.chk_data = !wr;
        if (push) begin
            if (p == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
        end
    endtask

    // Scoreboard: every completion pulse must match the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            for (int p = 0; p < 2; p++) begin
                if (port_data_ready[p]) begin
                    if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
                        checkOutput($sformatf("unexpected_dready_p%0d", p), 64'(port_data_ready[p]), 64'd0);
                    end else begin
                        e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        if (e.chk_data)
                            checkOutput($sformatf("read_data_p%0d", p), 64'(port_read_data[p]), 64'(e.data));
                        checkOutput($sformatf("error_p%0d", p), 64'(port_error[p]), 64'(e.err));
                    end
                end
            end
        end
    end

    task automatic readOne(input int p, input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        applyStimulus(p, 1'b0, 2'd2, addr, 32'd0, data, resp != 2'b00, 1'b1);
        tick();
        port_request[p] = 1'b0;
        checkOutput("rd_arvalid", 64'(arvalid), 64'd1);
        checkOutput("rd_arid", 64'(arid), 64'(p));
        checkOutput("rd_araddr", 64'(araddr), 64'(addr));
        tick();
        checkOutput("rd_arvalid_drop", 64'(arvalid), 64'd0);
        rvalid = 1'b1; rid = 4'(p); rdata = data; rresp = resp;
        tick();
        rvalid = 1'b0;
        checkOutput("rd_dready_latency", 64'(port_data_ready), 64'd1 << p);
        tick();
        checkOutput("rd_addr_ready_back", 64'(port_address_ready), 64'd3);
    endtask

    task automatic readBoth(input logic [3:0] first_id, input logic [31:0] d0, input logic [31:0] d1);
        applyStimulus(0, 1'b0, 2'd2, 32'h0000_0100, 32'd0, d0, 1'b0, 1'b1);
        applyStimulus(1, 1'b0, 2'd2, 32'h0000_0204, 32'd0, d1, 1'b0, 1'b1);
        tick();
        port_request = 2'b00;
        checkOutput("rr_first_valid", 64'(arvalid), 64'd1);
        checkOutput("rr_first_id", 64'(arid), 64'(first_id));
        tick();
        checkOutput("rr_second_valid", 64'(arvalid), 64'd1);
        checkOutput("rr_second_id", 64'(arid), 64'(first_id ^ 4'd1));
        tick();
        checkOutput("rr_ar_idle", 64'(arvalid), 64'd0);
        rvalid = 1'b1; rid = 4'd1; rdata = d1; rresp = 2'b00;
        tick();
        rid = 4'd0; rdata = d0;
        tick();
        rvalid = 1'b0;
        tick();
    endtask

    initial begin
        int ar_seen;
        reset = 1'b1;
        port_request = '0; port_write = '0; port_size = '0;
        port_address = '0; port_write_data = '0;
        arready = 1'b1; awready = 1'b1; wready = 1'b1;
        rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0;
        bvalid = 1'b0; bid = '0; bresp = '0;
        repeat (3) tick();
        reset = 1'b0;
        $display("[TB] reset state");
        checkOutput("rst_addr_ready", 64'(port_address_ready), 64'd3);
        checkOutput("rst_data_ready", 64'(port_data_ready), 64'd0);
        checkOutput("rst_error", 64'(port_error), 64'd0);
        checkOutput("rst_read_data", 64'(port_read_data), 64'd0);
        checkOutput("rst_valids", 64'({arvalid, awvalid, wvalid}), 64'd0);

        $display("[TB] single read");
        readOne(0, 32'h0000_1000, 32'hDEAD_BEEF, 2'b00);
        checkOutput("t1_arlen_burst", 64'({arlen, arburst, rready, bready}), 64'({8'd0, 2'b01, 1'b1, 1'b1}));

        $display("[TB] round-robin reads, out-of-order R");
        readBoth(4'd1, 32'hA0A0_0000, 32'hA1A1_1111);
        readOne(1, 32'h0000_0300, 32'h1111_2222, 2'b00);
        readBoth(4'd0, 32'hB0B0_0000, 32'hB1B1_1111);

        $display("[TB] byte write with delayed awready");
        applyStimulus(1, 1'b1, 2'd0, 32'h0000_2003, 32'hAA00_0000, 32'd0, 1'b0, 1'b1);
        awready = 1'b0; wready = 1'b1;
        tick();
        port_request = 2'b00;
        checkOutput("t3_aw_w_valid", 64'({awvalid, wvalid}), 64'd3);
        checkOutput("t3_ids", 64'({awid, wid}), 64'h11);
        checkOutput("t3_wstrb", 64'(wstrb), 64'b1000);
        checkOutput("t3_wdata", 64'(wdata), 64'hAA00_0000);
        checkOutput("t3_awaddr_size", 64'({awaddr, awsize, wlast}), 64'({32'h0000_2003, 3'd0, 1'b1}));
        tick();
        checkOutput("t3_w_dropped", 64'({awvalid, wvalid}), 64'b10);
        tick();
        checkOutput("t3_aw_stable", 64'({awvalid, awaddr}), 64'({1'b1, 32'h0000_2003}));
        tick();
        awready = 1'b1;
        checkOutput("t3_aw_still", 64'(awvalid), 64'd1);
        tick();
        checkOutput("t3_aw_done", 64'({awvalid, wvalid}), 64'd0);
        bvalid = 1'b1; bid = 4'd1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        checkOutput("t3_dready", 64'(port_data_ready), 64'b10);
        tick();
        checkOutput("t3_single_dready", 64'(port_data_ready), 64'd0);

        $display("[TB] read-after-write hazard");
        applyStimulus(1, 1'b1, 2'd2, 32'h0000_3000, 32'h1234_5678, 32'd0, 1'b0, 1'b1);
        tick();
        port_request[1] = 1'b0;
        applyStimulus(0, 1'b0, 2'd1, 32'h0000_3002, 32'd0, 32'hCAFE_0000, 1'b0, 1'b1);
        tick();
        port_request[0] = 1'b0;
        ar_seen = 0;
        repeat (10) begin
            if (arvalid) ar_seen++;
            tick();
        end
        checkOutput("t4_hazard_stall", 64'(ar_seen), 64'd0);
        bvalid = 1'b1; bid = 4'd1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        checkOutput("t4_write_respond", 64'(port_data_ready), 64'b10);
        checkOutput("t4_stall_in_respond", 64'(arvalid), 64'd0);
        tick();
        checkOutput("t4_hazard_release", 64'({arvalid, arid}), 64'({1'b1, 4'd0}));
        checkOutput("t4_release_addr", 64'(araddr), 64'h0000_3002);
        tick();
        rvalid = 1'b1; rid = 4'd0; rdata = 32'hCAFE_0000; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        tick();

        applyStimulus(1, 1'b1, 2'd2, 32'h0000_3000, 32'h8765_4321, 32'd0, 1'b0, 1'b1);
        tick();
        port_request[1] = 1'b0;
        applyStimulus(0, 1'b0, 2'd2, 32'h0000_3004, 32'd0, 32'h1357_2468, 1'b0, 1'b1);
        tick();
        port_request[0] = 1'b0;
        checkOutput("t4_no_hazard", 64'(arvalid), 64'd1);
        checkOutput("t4_no_hazard_addr", 64'(araddr), 64'h0000_3004);
        tick();
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h1357_2468; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        repeat (2) tick();
        bvalid = 1'b1; bid = 4'd1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        tick();

        $display("[TB] error response");
        readOne(0, 32'h0000_0500, 32'hBAD0_BAD0, 2'b10);
        checkOutput("t5_error_held", 64'(port_error[0]), 64'd1);
        readOne(0, 32'h0000_0504, 32'h600D_F00D, 2'b00);
        checkOutput("t5_error_cleared", 64'(port_error[0]), 64'd0);

        $display("[TB] reset mid-transfer");
        arready = 1'b0;
        applyStimulus(0, 1'b0, 2'd2, 32'h0000_0700, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        port_request = 2'b00;
        checkOutput("t6_pending", 64'({arvalid, arid}), 64'({1'b1, 4'd0}));
        tick();
        checkOutput("t6_stable", 64'({arvalid, araddr}), 64'({1'b1, 32'h0000_0700}));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("t6_arvalid_clear", 64'(arvalid), 64'd0);
        checkOutput("t6_addr_ready", 64'(port_address_ready), 64'd3);
        checkOutput("t6_rdata_cleared", 64'(port_read_data), 64'd0);
        arready = 1'b1;
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h5555_AAAA; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        tick();
        checkOutput("t6_no_dready", 64'(port_data_ready), 64'd0);
        tick();

        checkOutput("sb_q0_drained", 64'(exp_q0.size()), 64'd0);
        checkOutput("sb_q1_drained", 64'(exp_q1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
